// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor computing D = A - B - Bin one bit per clock.
// The LSB goes first. Borrow-out and two's-complement overflow are produced with
// the result. D, Bout and V are registered and change only when an operation
// completes.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              brw_q, brw_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic              bout_q, bout_d;
   logic              v_q, v_d;

   // Single-bit full subtractor on the current operand LSBs
   logic bit_a, bit_b, diff_bit, brw_nxt;
   always_comb begin
      bit_a    = a_q[0];
      bit_b    = b_q[0];
      diff_bit = bit_a ^ bit_b ^ brw_q;
      brw_nxt  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);
   end

   // Next-state and datapath control for the IDLE/SHIFT/DONE sequencer
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      v_d     = v_q;
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts start the same way IDLE does, so operations can run back-to-back
            if (start) begin
               state_d = SHIFT;
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {diff_bit, res_q[WIDTH-1:1]};
            brw_d = brw_nxt;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               // On the last bit a_q[0]/b_q[0] are the original operand MSBs
               d_d     = {diff_bit, res_q[WIDTH-1:1]};
               bout_d  = brw_nxt;
               v_d     = (bit_a != bit_b) && (diff_bit != bit_a);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign D    = d_q;
   assign Bout = bout_q;
   assign V    = v_q;

endmodule
